// File: rtl/rtc_timer_if.sv
// Bus and host-time signals between the CPU bus fabric and rtc_timer.
// The master drives the bus strobes and host load. The slave (the timer) drives read data and the pulses.
interface rtc_timer_if;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic [23:0] host_seconds;
  logic        host_seconds_valid;
  logic        validate_rtc;
  logic        tick_1hz;

  modport master (
    output bus_write, bus_read, bus_address_in, bus_data_in,
    output host_seconds, host_seconds_valid,
    input  bus_data_out, validate_rtc, tick_1hz
  );

  modport slave (
    input  bus_write, bus_read, bus_address_in, bus_data_in,
    input  host_seconds, host_seconds_valid,
    output bus_data_out, validate_rtc, tick_1hz
  );
endinterface

// File: rtl/rtc_timer.sv
// 24-bit RTC seconds counter at 0x2008-0x200B, with a clk_ce prescaler and a one-shot host time load.
// Reading 0x2009 snapshots counter[23:8] into the shadow so that a multi-byte read stays coherent.
module rtc_timer #(
  parameter int CE_FREQ = 4000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_ce,
  rtc_timer_if.slave bus
);
  localparam int PW = (CE_FREQ > 2) ? $clog2(CE_FREQ) : 1;
  localparam logic [PW-1:0] P_TC = PW'(CE_FREQ - 1);

  logic          r_run;
  logic [23:0]   r_counter;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_shadow;
  logic          r_load_pending;
  logic [23:0]   r_load_value;
  logic          r_validate;
  logic          r_tick;

  logic w_wr_ctrl, w_rd_lo, w_clear;
  logic w_unused_data;

  assign w_wr_ctrl     = clk_ce && bus.bus_write && (bus.bus_address_in == 24'h002008);
  assign w_rd_lo       = clk_ce && bus.bus_read  && (bus.bus_address_in == 24'h002009);
  assign w_clear       = w_wr_ctrl && bus.bus_data_in[1];
  assign w_unused_data = ^bus.bus_data_in[7:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run          <= 1'b0;
      r_counter      <= '0;
      r_presc        <= '0;
      r_shadow       <= '0;
      r_load_pending <= 1'b0;
      r_load_value   <= '0;
      r_validate     <= 1'b0;
      r_tick         <= 1'b0;
    end else begin
      if (clk_ce) begin
        r_validate <= r_load_pending;
        r_tick     <= 1'b0;
        if (w_wr_ctrl) r_run <= bus.bus_data_in[0];
        if (w_rd_lo)   r_shadow <= r_counter[23:8];
        // Host apply outranks the register clear, which outranks the tick; a pre-empted tick is lost.
        if (r_load_pending) begin
          r_counter      <= r_load_value;
          r_presc        <= '0;
          r_load_pending <= 1'b0;
        end else if (w_clear) begin
          r_counter <= '0;
          r_presc   <= '0;
        end else if (r_run) begin
          if (r_presc == P_TC) begin
            r_presc   <= '0;
            r_counter <= r_counter + 24'd1;
            r_tick    <= 1'b1;
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
      end
      // The host pulse is one clk wide, so it must be caught even when clk_ce is low.
      if (bus.host_seconds_valid) begin
        r_load_value   <= bus.host_seconds;
        r_load_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.bus_data_out = 8'h00;
    case (bus.bus_address_in)
      24'h002008: bus.bus_data_out = {7'b0, r_run};
      24'h002009: bus.bus_data_out = r_counter[7:0];
      24'h00200A: bus.bus_data_out = r_shadow[7:0];
      24'h00200B: bus.bus_data_out = r_shadow[15:8];
      default:    bus.bus_data_out = 8'h00;
    endcase
  end

  assign bus.validate_rtc = r_validate;
  assign bus.tick_1hz     = r_tick;
endmodule

// File: tb/tb_rtc_timer.sv
// Directed bench for rtc_timer with CE_FREQ=4: prescaler ticks, host load, wrap, snapshot, priority, reset.
module tb_rtc_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_ce = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  rtc_timer_if bus ();

  rtc_timer #(.CE_FREQ(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_ce (clk_ce),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_pulse(input logic [23:0] v);
    bus.host_seconds       = v;
    bus.host_seconds_valid = 1'b1;
    step();
    bus.host_seconds_valid = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    bus.bus_address_in = 24'h002008;
    bus.bus_data_in    = d;
    bus.bus_write      = 1'b1;
    step();
    bus.bus_write      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.bus_address_in = 24'h002008;
    repeat (2) step();
    n_vec++; if (bus.bus_data_out !== 8'h00) begin n_err++; $display("FAIL rst_ctrl got %h want 00", bus.bus_data_out); end
    n_vec++; if (bus.validate_rtc !== 1'b0 || bus.tick_1hz !== 1'b0) begin n_err++; $display("FAIL rst_pulses got %b%b want 00", bus.validate_rtc, bus.tick_1hz); end
    reset = 1'b0;
    step();
    bus.bus_address_in = 24'h002009;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h00) begin n_err++; $display("FAIL rst_cnt got %h want 00", bus.bus_data_out); end
  endtask

  task automatic test_prescaler();
    int ticks = 0;
    wr_ctrl(8'h01);
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.tick_1hz === 1'b1) ticks++;
    end
    n_vec++; if (ticks != 3) begin n_err++; $display("FAIL tick_count got %0d want 3", ticks); end
    bus.bus_address_in = 24'h002009;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h03) begin n_err++; $display("FAIL cnt_lo got %h want 03", bus.bus_data_out); end
    bus.bus_read = 1'b1;
    step();
    bus.bus_read = 1'b0;
    bus.bus_address_in = 24'h00200A;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h00) begin n_err++; $display("FAIL shadow_lo got %h want 00", bus.bus_data_out); end
  endtask

  task automatic test_host_load();
    clk_ce = 1'b0;
    host_pulse(24'h123456);
    repeat (4) step();
    n_vec++; if (bus.validate_rtc !== 1'b0) begin n_err++; $display("FAIL vld_early got %b want 0", bus.validate_rtc); end
    clk_ce = 1'b1;
    step();
    bus.bus_address_in = 24'h002009;
    #1;
    n_vec++; if (bus.validate_rtc !== 1'b1) begin n_err++; $display("FAIL vld_pulse got %b want 1", bus.validate_rtc); end
    n_vec++; if (bus.bus_data_out !== 8'h56) begin n_err++; $display("FAIL load_lo got %h want 56", bus.bus_data_out); end
    bus.bus_read = 1'b1;
    step();
    bus.bus_read = 1'b0;
    n_vec++; if (bus.validate_rtc !== 1'b0) begin n_err++; $display("FAIL vld_clear got %b want 0", bus.validate_rtc); end
    bus.bus_address_in = 24'h00200A;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h34) begin n_err++; $display("FAIL load_mid got %h want 34", bus.bus_data_out); end
    bus.bus_address_in = 24'h00200B;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h12) begin n_err++; $display("FAIL load_hi got %h want 12", bus.bus_data_out); end
  endtask

  task automatic test_wrap();
    host_pulse(24'hFFFFFF);
    step();
    repeat (3) step();
    n_vec++; if (bus.tick_1hz !== 1'b0) begin n_err++; $display("FAIL wrap_early got %b want 0", bus.tick_1hz); end
    step();
    bus.bus_address_in = 24'h002009;
    #1;
    n_vec++; if (bus.tick_1hz !== 1'b1) begin n_err++; $display("FAIL wrap_tick got %b want 1", bus.tick_1hz); end
    n_vec++; if (bus.bus_data_out !== 8'h00) begin n_err++; $display("FAIL wrap_cnt got %h want 00", bus.bus_data_out); end
    clk_ce = 1'b0;
    step();
    n_vec++; if (bus.tick_1hz !== 1'b1) begin n_err++; $display("FAIL tick_hold got %b want 1", bus.tick_1hz); end
    clk_ce = 1'b1;
    step();
    n_vec++; if (bus.tick_1hz !== 1'b0) begin n_err++; $display("FAIL tick_drop got %b want 0", bus.tick_1hz); end
  endtask

  task automatic test_snapshot();
    host_pulse(24'h0001FF);
    step();
    bus.bus_address_in = 24'h002009;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'hFF) begin n_err++; $display("FAIL snap_lo got %h want FF", bus.bus_data_out); end
    bus.bus_read = 1'b1;
    step();
    bus.bus_read = 1'b0;
    repeat (3) step();
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h00) begin n_err++; $display("FAIL snap_newlo got %h want 00", bus.bus_data_out); end
    bus.bus_address_in = 24'h00200A;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h01) begin n_err++; $display("FAIL snap_shadow got %h want 01", bus.bus_data_out); end
  endtask

  task automatic test_priority();
    host_pulse(24'h000005);
    step();
    repeat (3) step();
    wr_ctrl(8'h03);
    n_vec++; if (bus.tick_1hz !== 1'b0) begin n_err++; $display("FAIL clr_tick got %b want 0", bus.tick_1hz); end
    n_vec++; if (bus.bus_data_out !== 8'h01) begin n_err++; $display("FAIL clr_run got %h want 01", bus.bus_data_out); end
    bus.bus_address_in = 24'h002009;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h00) begin n_err++; $display("FAIL clr_cnt got %h want 00", bus.bus_data_out); end
    repeat (4) step();
    n_vec++; if (bus.bus_data_out !== 8'h01) begin n_err++; $display("FAIL clr_presc got %h want 01", bus.bus_data_out); end
    host_pulse(24'h000020);
    step();
    repeat (2) step();
    host_pulse(24'h000010);
    wr_ctrl(8'h03);
    n_vec++; if (bus.bus_data_out !== 8'h01) begin n_err++; $display("FAIL apply_run got %h want 01", bus.bus_data_out); end
    n_vec++; if (bus.validate_rtc !== 1'b1 || bus.tick_1hz !== 1'b0) begin n_err++; $display("FAIL apply_pulses got %b%b want 10", bus.validate_rtc, bus.tick_1hz); end
    bus.bus_address_in = 24'h002009;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h10) begin n_err++; $display("FAIL apply_cnt got %h want 10", bus.bus_data_out); end
    repeat (4) step();
    n_vec++; if (bus.bus_data_out !== 8'h11) begin n_err++; $display("FAIL apply_next got %h want 11", bus.bus_data_out); end
  endtask

  task automatic test_reset_mid_pulse();
    host_pulse(24'h000077);
    bus.host_seconds       = 24'h000099;
    bus.host_seconds_valid = 1'b1;
    step();
    bus.host_seconds_valid = 1'b0;
    n_vec++; if (bus.validate_rtc !== 1'b1) begin n_err++; $display("FAIL mid_vld got %b want 1", bus.validate_rtc); end
    #2;
    reset = 1'b1;
    bus.bus_address_in = 24'h002008;
    #1;
    n_vec++; if (bus.validate_rtc !== 1'b0 || bus.tick_1hz !== 1'b0) begin n_err++; $display("FAIL mid_drop got %b%b want 00", bus.validate_rtc, bus.tick_1hz); end
    n_vec++; if (bus.bus_data_out !== 8'h00) begin n_err++; $display("FAIL mid_run got %h want 00", bus.bus_data_out); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (bus.validate_rtc !== 1'b0) begin n_err++; $display("FAIL post_vld got %b want 0 (cycle %0d)", bus.validate_rtc, i); end
    end
    n_vec++; if (bus.bus_data_out !== 8'h00) begin n_err++; $display("FAIL post_run got %h want 00", bus.bus_data_out); end
    bus.bus_address_in = 24'h002009;
    #1;
    n_vec++; if (bus.bus_data_out !== 8'h00) begin n_err++; $display("FAIL post_cnt got %h want 00", bus.bus_data_out); end
  endtask

  initial begin
    bus.bus_write          = 1'b0;
    bus.bus_read           = 1'b0;
    bus.bus_address_in     = 24'h0;
    bus.bus_data_in        = 8'h00;
    bus.host_seconds       = 24'h0;
    bus.host_seconds_valid = 1'b0;
    test_reset();
    test_prescaler();
    test_host_load();
    test_wrap();
    test_snapshot();
    test_priority();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rtc_timer.md
Name: rtc_timer

Overview:
- Real-time clock stage feeding system_control.
- Implements the 24-bit seconds counter at 0x2008-0x200B.
- Accepts a one-shot host time load and produces the validate_rtc pulse that system_control uses to set its RTC-valid bit.
- Sits on the CPU bus beside system_control; its bus_data_out is OR-combined into the bus read mux.

Parameters:
- CE_FREQ, 4000000, number of clk_ce cycles per second; prescaler terminal count is CE_FREQ-1. Must be ≥2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- clk_ce  input  1  CPU clock enable; all state except the load-pending flag advances only when high.
- bus_write  input  1  write strobe, qualified by clk_ce.
- bus_read  input  1  read strobe, qualified by clk_ce.
- bus_address_in  input  24  bus address.
- bus_data_in  input  8  write data.
- bus_data_out  output  8  read data; 0 when the address is not decoded.
- host_seconds  input  24  host-supplied seconds value.
- host_seconds_valid  input  1  single-clk pulse; host_seconds is valid in the same cycle.
- validate_rtc  output  1  one-clk_ce-cycle pulse after a host load is applied.
- tick_1hz  output  1  one-clk_ce-cycle pulse on each seconds increment.

Behaviour:
- Reset (async, any time) clears to 0:
  - run, counter[23:0], prescaler, shadow[15:0], load_pending, load_value;
  - validate_rtc and tick_1hz.
  - A pending host load is discarded.
- Host capture, on every clk edge regardless of clk_ce:
  - if host_seconds_valid, load_value <= host_seconds and load_pending <= 1;
  - a second pulse before apply overwrites load_value.
- Apply, on a clk_ce cycle with load_pending=1:
  - counter <= load_value, prescaler <= 0, load_pending <= 0;
  - validate_rtc <= 1 for exactly that one clk_ce period, cleared at the next clk_ce edge;
  - this holds the pulse across system_control's clk_ce sample;
  - run is unaffected.
- Prescaler, on clk_ce cycles:
  - if run=1 and no apply, prescaler increments;
  - at CE_FREQ-1 it wraps to 0, counter increments, and tick_1hz <= 1 for one clk_ce period;
  - if run=0, prescaler and counter hold.
- Counter wraps 0xFFFFFF -> 0x000000 with no flag.
- Register map (writes take effect on the clk_ce edge where bus_write=1 and the address matches):
  - 0x2008 write: run <= data[0]; data[1]=1 clears counter and prescaler (self-clearing, not stored); data[7:2] ignored.
  - 0x2008 read: {7'b0, run}.
  - 0x2009 read: counter[7:0]; when bus_read and clk_ce, also shadow <= counter[23:8].
  - 0x200A read: shadow[7:0].
  - 0x200B read: shadow[15:8].
  - Writes to 0x2009-0x200B are ignored.
- bus_data_out is combinational from address and state; reads have no side effect except the 0x2009 snapshot.
- Priority within one clk_ce cycle (highest first): host apply > register clear > prescaler tick.
  - A tick coinciding with clear or apply is dropped and tick_1hz stays 0.
  - A run write in the same cycle as an apply still updates run.
- Reset mid-pulse: validate_rtc and tick_1hz drop immediately (async).
- clk_ce low: all outputs hold their values, including validate_rtc and tick_1hz.

Test Plan:
- CE_FREQ=4, clk_ce always 1: reset, write 0x2008=0x01, wait 12 ce -> tick_1hz pulses 3 times; read 0x2009 = 0x03; read 0x200A = 0x00.
- host_seconds=0x123456 with one-clk valid pulse while clk_ce=0 for 5 clks, then clk_ce=1 -> counter=0x123456 on first ce edge; validate_rtc high exactly one ce period; 0x2009 reads 0x56, then 0x200A = 0x34 and 0x200B = 0x12.
- Load 0xFFFFFF, run=1, CE_FREQ=4 -> after 4 ce, counter=0x000000, tick_1hz=1.
- Snapshot coherency: counter=0x0001FF, read 0x2009 (0xFF); let counter tick to 0x000200; read 0x200A -> 0x01 (shadow), not 0x02.
- Simultaneous events: write 0x2008=0x03 on the ce where prescaler=CE_FREQ-1 -> counter=0, no tick_1hz. Same cycle plus an apply of 0x000010 -> counter=0x000010, validate_rtc=1, run=1.
- Assert reset mid validate_rtc pulse and with load_pending=1 -> all outputs 0 immediately; after release, no validate_rtc and 0x2008 reads 0x00.
